// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// Frame layout, shifted out LSB first: {stop, parity, data[7:0]}.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        START   = 3'd2,
        SHIFT   = 3'd3,
        ACK     = 3'd4,
        RELEASE = 3'd5,
        DONE    = 3'd6
    } ps2_state_t;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_NOACK   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam int FRAME_BITS = 10;

    // PS/2 uses odd parity over the eight data bits
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [7:0] data);
        return {1'b1, odd_parity(data), data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions one raw PS/2 pin: 2-FF synchronizer, FILT_LEN-sample glitch
// filter, and a one-cycle pulse when the filtered level falls.
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          fall_r;
    logic [CW-1:0] cnt_r;
    logic          flip_s;

    // a new level is accepted on the FILT_LEN-th consecutive differing sample
    assign flip_s = (sync2_r != level_r) && (cnt_r == CNT_LAST);

    // metastability synchronizer; idle bus level is high
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // glitch filter and falling-edge pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            level_r <= 1'b1;
            cnt_r   <= '0;
            fall_r  <= 1'b0;
        end else begin
            fall_r <= flip_s & level_r;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (flip_s) begin
                level_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign level = level_r;
    assign fall  = fall_r;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. Drives PS2C/PS2D open-drain
// through output-enables and reports the frame outcome on done/err.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILT_LEN       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2c_in,
    input  logic       ps2d_in,
    input  logic       wr,
    input  logic [7:0] din,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [INH_W-1:0] INH_PRE  = INH_W'(INHIBIT_CYCLES - 2);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

    ps2_state_t            state_r;
    ps2_state_t            state_nx_s;
    logic [FRAME_BITS-1:0] frame_r;
    logic [FRAME_BITS-1:0] frame_nx_s;
    logic [3:0]            bitcnt_r;
    logic [3:0]            bitcnt_nx_s;
    logic [INH_W-1:0]      inh_cnt_r;
    logic [INH_W-1:0]      inh_nx_s;
    logic [TO_W-1:0]       to_cnt_r;
    logic [TO_W-1:0]       to_nx_s;
    logic [1:0]            err_r;
    logic [1:0]            err_nx_s;
    logic                  c_oe_r;
    logic                  c_oe_nx_s;
    logic                  d_oe_r;
    logic                  d_oe_nx_s;
    logic                  busy_r;
    logic                  done_r;

    logic                  c_level_s;
    logic                  c_fall_s;
    logic                  d_level_s;
    logic                  d_fall_unused_s;
    logic                  timing_s;
    logic                  timeout_s;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_c_filt (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2c_in),
        .level (c_level_s),
        .fall  (c_fall_s)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_d_filt (
        .clk   (clk),
        .rst   (rst),
        .raw   (ps2d_in),
        .level (d_level_s),
        .fall  (d_fall_unused_s)
    );

    assign timing_s  = (state_r == START) || (state_r == SHIFT) ||
                       (state_r == ACK)   || (state_r == RELEASE);
    assign timeout_s = timing_s && (to_cnt_r == TO_LAST);

    // next-state, frame shifting and line-drive decisions
    always_comb begin
        state_nx_s  = state_r;
        frame_nx_s  = frame_r;
        bitcnt_nx_s = bitcnt_r;
        inh_nx_s    = inh_cnt_r;
        err_nx_s    = err_r;
        c_oe_nx_s   = 1'b0;
        d_oe_nx_s   = d_oe_r;
        if (timeout_s) begin
            // a stalled device overrides any pending result
            state_nx_s = DONE;
            err_nx_s   = ERR_TIMEOUT;
            d_oe_nx_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    d_oe_nx_s = 1'b0;
                    if (wr) begin
                        state_nx_s  = INHIBIT;
                        frame_nx_s  = build_frame(din);
                        bitcnt_nx_s = 4'd0;
                        inh_nx_s    = '0;
                        err_nx_s    = ERR_OK;
                        c_oe_nx_s   = 1'b1;
                    end else begin
                        inh_nx_s = '0;
                    end
                end
                INHIBIT: begin
                    c_oe_nx_s = 1'b1;
                    inh_nx_s  = inh_cnt_r + INH_W'(1);
                    if (inh_cnt_r == INH_LAST) begin
                        state_nx_s = START;
                        c_oe_nx_s  = 1'b0;
                        d_oe_nx_s  = 1'b1;
                    end else if (inh_cnt_r == INH_PRE) begin
                        // data low is asserted one cycle before clock release
                        d_oe_nx_s = 1'b1;
                    end else begin
                        d_oe_nx_s = 1'b0;
                    end
                end
                START: begin
                    if (c_fall_s) begin
                        d_oe_nx_s   = ~frame_r[0];
                        bitcnt_nx_s = 4'd1;
                        state_nx_s  = SHIFT;
                    end else begin
                        d_oe_nx_s = 1'b1;
                    end
                end
                SHIFT: begin
                    if (c_fall_s) begin
                        frame_nx_s  = frame_r >> 1;
                        d_oe_nx_s   = ~frame_r[1];
                        bitcnt_nx_s = bitcnt_r + 4'd1;
                        if (bitcnt_r == LAST_BIT) begin
                            state_nx_s = ACK;
                        end else begin
                            state_nx_s = SHIFT;
                        end
                    end else begin
                        d_oe_nx_s = d_oe_r;
                    end
                end
                ACK: begin
                    d_oe_nx_s = 1'b0;
                    if (c_fall_s) begin
                        err_nx_s   = d_level_s ? ERR_NOACK : err_r;
                        state_nx_s = RELEASE;
                    end else begin
                        state_nx_s = ACK;
                    end
                end
                RELEASE: begin
                    d_oe_nx_s = 1'b0;
                    if (c_level_s && d_level_s) begin
                        state_nx_s = DONE;
                    end else begin
                        state_nx_s = RELEASE;
                    end
                end
                DONE: begin
                    d_oe_nx_s  = 1'b0;
                    state_nx_s = IDLE;
                end
                default: begin
                    d_oe_nx_s  = 1'b0;
                    state_nx_s = IDLE;
                end
            endcase
        end
    end

    // device-activity watchdog: restarts on every fall and every state change
    always_comb begin
        if (timing_s && (state_nx_s == state_r) && !c_fall_s) begin
            to_nx_s = to_cnt_r + TO_W'(1);
        end else begin
            to_nx_s = '0;
        end
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            frame_r   <= '0;
            bitcnt_r  <= 4'd0;
            inh_cnt_r <= '0;
            to_cnt_r  <= '0;
            err_r     <= ERR_OK;
            c_oe_r    <= 1'b0;
            d_oe_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            frame_r   <= frame_nx_s;
            bitcnt_r  <= bitcnt_nx_s;
            inh_cnt_r <= inh_nx_s;
            to_cnt_r  <= to_nx_s;
            err_r     <= err_nx_s;
            c_oe_r    <= c_oe_nx_s;
            d_oe_r    <= d_oe_nx_s;
            busy_r    <= (state_nx_s != IDLE);
            done_r    <= (state_nx_s == DONE);
        end
    end

    assign ps2c_oe = c_oe_r;
    assign ps2d_oe = d_oe_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign err     = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// host and the received bits are compared with a frame model built from the byte.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 300;
    localparam int FL  = 8;
    localparam int LO  = 40;
    localparam int HI  = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       dev_c = 1'b1;
    logic       dev_d = 1'b1;
    logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe, busy, done;
    logic [1:0] err;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_fall = 0;
    int done_cnt = 0;
    int done_at = 0;
    logic done_busy = 1'b0;
    logic [10:0] got;
    int at;
    int base;
    logic [7:0] rb;

    // open-drain wired-AND of host and device
    assign ps2c_in = dev_c & ~ps2c_oe;
    assign ps2d_in = dev_d & ~ps2d_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILT_LEN(FL)) dut (
        .clk     (clk),
        .rst     (rst),
        .ps2c_in (ps2c_in),
        .ps2d_in (ps2d_in),
        .wr      (wr),
        .din     (din),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done) begin
            done_cnt  <= done_cnt + 1;
            done_at   <= cyc;
            done_busy <= busy;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // expected wire sequence: start, data LSB first, odd parity, stop
    function automatic logic [10:0] model_frame(input int unsigned v);
        logic [10:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            ones += (v >> i) & 1;
            f[i+1] = ((v >> i) & 1) != 0;
        end
        f[0]  = 1'b0;
        f[9]  = (ones % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_frame(input logic [7:0] d);
        int hi;
        int dfirst;
        din = d;
        wr  = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        check("busy_rise", busy, 1);
        check("err_clear", err, 0);
        hi = 0;
        dfirst = -1;
        while (ps2c_oe && hi < INH + 20) begin
            if (ps2d_oe && dfirst < 0) dfirst = hi;
            hi++;
            @(negedge clk);
        end
        check("inhibit_len", hi, INH);
        check("data_lead", dfirst, INH - 1);
        check("start_drive", ps2d_oe, 1);
    endtask

    task automatic device_clock(input int nclk, input bit ack, input bit glitch,
                                output logic [10:0] bits);
        bits = '0;
        repeat (20) @(negedge clk);
        bits[0] = ps2d_in;
        for (int i = 1; i <= nclk; i++) begin
            dev_c = 1'b0;
            last_fall = cyc;
            repeat (LO) @(negedge clk);
            if (i <= 10) bits[i] = ps2d_in;
            dev_c = 1'b1;
            if (i == 10 && ack) begin
                repeat (HI / 2) @(negedge clk);
                dev_d = 1'b0;
                repeat (HI / 2) @(negedge clk);
            end else if (i == 3 && glitch) begin
                repeat (10) @(negedge clk);
                dev_c = 1'b0;
                repeat (3) @(negedge clk);
                dev_c = 1'b1;
                repeat (HI - 13) @(negedge clk);
            end else begin
                repeat (HI) @(negedge clk);
            end
        end
        if (nclk == 11) begin
            repeat (10) @(negedge clk);
            dev_d = 1'b1;
        end
    endtask

    task automatic end_frame(input logic [1:0] exp_err, input int budget,
                             input int b, output int t);
        for (int k = 0; k < budget && done_cnt == b; k++) @(negedge clk);
        check("done_seen", done_cnt != b, 1);
        repeat (30) @(negedge clk);
        check("done_once", done_cnt - b, 1);
        check("done_busy", done_busy, 1);
        check("err_code", err, exp_err);
        check("oe_released", {ps2c_oe, ps2d_oe}, 0);
        check("idle_busy", busy, 0);
        t = done_at;
    endtask

    task automatic frame(input logic [7:0] d, input bit ack, input bit glitch,
                         output logic [10:0] bits);
        int b;
        int t;
        b = done_cnt;
        start_frame(d);
        device_clock(11, ack, glitch, bits);
        check("frame_bits", bits, model_frame(d));
        end_frame(ack ? 2'b00 : 2'b01, 400, b, t);
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_oe", {ps2c_oe, ps2d_oe}, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst = 1'b1;
        repeat (10) @(negedge clk);

        // directed bytes with distinctive parity
        frame(8'hED, 1'b1, 1'b0, got);
        check("parity_ED", got[9], 1);
        frame(8'hF4, 1'b1, 1'b0, got);
        check("parity_F4", got[9], 0);
        frame(8'h00, 1'b1, 1'b0, got);
        check("parity_00", got[9], 1);
        check("data_00", got[8:1], 0);

        // no acknowledge, then a frame that must clear err
        rb = 8'($urandom_range(0, 255));
        frame(rb, 1'b0, 1'b0, got);
        frame(8'hFF, 1'b1, 1'b0, got);

        // device stalls after the 4th fall; wr during the stall is ignored
        base = done_cnt;
        start_frame(8'hA5);
        device_clock(4, 1'b0, 1'b0, got);
        din = 8'h3C;
        wr  = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        check("stall_busy", busy, 1);
        end_frame(2'b10, TO + 100, base, at);
        check("timeout_delay", (at - last_fall >= TO + 5) && (at - last_fall <= TO + 20), 1);
        check("no_restart", ps2c_oe, 0);
        frame(8'hA5, 1'b1, 1'b0, got);

        // reset in the middle of SHIFT
        base = done_cnt;
        start_frame(8'h5A);
        device_clock(3, 1'b0, 1'b0, got);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_oe", {ps2c_oe, ps2d_oe}, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_idle", {busy, ps2c_oe}, 0);
        check("rst_no_done", done_cnt - base, 0);
        frame(8'h5A, 1'b1, 1'b0, got);

        // short clock glitch must not advance the bit count
        rb = 8'($urandom_range(0, 255));
        frame(rb, 1'b1, 1'b1, got);

        // random bytes and acknowledge behaviour
        for (int n = 0; n < 5; n++) begin
            rb = 8'($urandom_range(0, 255));
            frame(rb, 1'($urandom_range(0, 3) != 0), 1'b0, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) from the CPU's IO bus to the keyboard over the same PS2C/PS2D pair that the keyboard receiver listens on.
- Drives the lines open-drain via output-enables. The top level ties PS2C = ps2c_oe ? 1'b0 : 1'bz, and the same for PS2D.
- busy is used by the IO wrapper to hold off the receiver during a host frame.

Parameters:
- INHIBIT_CYCLES, 5000: clk cycles PS2C is held low before the request-to-send (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum clk cycles between consecutive device clock falling edges, or spent waiting for line release (15 ms at 50 MHz).
- FILT_LEN, 8: number of consecutive equal samples needed to accept a new filtered line level.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low (asserted when rst==0, sampled on posedge clk)
- ps2c_in  in  1  raw PS2C pin level
- ps2d_in  in  1  raw PS2D pin level
- wr  in  1  one-cycle write strobe; accepted only when busy==0
- din  in  8  command byte, captured on the accepted wr
- ps2c_oe  out  1  1 = pull PS2C low
- ps2d_oe  out  1  1 = pull PS2D low
- busy  out  1  frame in progress (any state other than IDLE)
- done  out  1  one-cycle pulse when a frame ends, whether OK or error
- err  out  2  result of the last frame: 00 OK, 01 no ACK, 10 timeout; held until the next accepted wr

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE; ps2c_oe=0, ps2d_oe=0, busy=0, done=0, err=00.
  - Counters and shift register are cleared.
  - Reset mid-frame releases both lines on that same edge. No partial frame resumes.
- Input conditioning: each raw pin passes through a 2-FF synchronizer, then the FILT_LEN glitch filter. A falling edge (fall) is a 1-cycle pulse when filtered PS2C goes 1->0.
- Frame register, 10 bits, LSB shifted out first: {stop=1, parity, din[7:0]}.
  - parity = ~^din (odd parity).
  - ps2d_oe = ~frame[0] while shifting.
- States:
  - IDLE:
    - Outputs: oe=00, busy=0.
    - On wr: capture din, clear err, go to INHIBIT. busy rises the next cycle.
  - INHIBIT:
    - Outputs: ps2c_oe=1, ps2d_oe=0. Counts INHIBIT_CYCLES.
    - On the last count: ps2d_oe=1 (data low asserted before clock release), go to START.
  - START:
    - Outputs: ps2c_oe=0, ps2d_oe=1 (start bit).
    - Waits for the first fall, then drives frame[0] (d0), bitcnt=1, go to SHIFT.
  - SHIFT:
    - Each fall shifts the frame register right and drives the next bit.
    - Falls 2..8 drive d1..d7, fall 9 drives parity, fall 10 drives stop (ps2d_oe=0).
    - After fall 10, go to ACK.
  - ACK:
    - Outputs: oe=00.
    - On the next fall (11th), sample filtered PS2D: 0 -> ack_ok, 1 -> err=01.
    - Go to RELEASE.
  - RELEASE:
    - Wait until filtered PS2C==1 and PS2D==1, then go to DONE.
  - DONE:
    - 1 cycle: done=1, busy still 1.
    - Go to IDLE; the next wr is accepted the cycle after.
- Timeout:
  - A counter resets on every fall and on each state entry. It runs in START, SHIFT, ACK and RELEASE.
  - When it reaches TIMEOUT_CYCLES: oe=00, err=10, go to DONE.
  - A timeout overrides a pending 01 result.
- wr while busy is ignored; din is not recaptured.
- Total latency, wr to done:
  - INHIBIT_CYCLES + 11 device clocks + release wait + filter latency (2 + FILT_LEN cycles per edge).
- A device clock glitch shorter than FILT_LEN cycles produces no fall and no bit advance.

Decomposition:
- Package ps2_pkg:
  - state enum: IDLE, INHIBIT, START, SHIFT, ACK, RELEASE, DONE.
  - err codes: ERR_OK=2'b00, ERR_NOACK=2'b01, ERR_TIMEOUT=2'b10.
  - frame-length constant: FRAME_BITS=10.
- One sub-module, ps2_line_filter (synchronizer, glitch filter, fall pulse, parameter FILT_LEN), instantiated twice: once for PS2C, once for PS2D.

Test Plan:
- Reset: rst=0 for 3 cycles while a frame is in SHIFT -> ps2c_oe=0, ps2d_oe=0, busy=0, err=00 on the first reset edge; a later wr starts a fresh INHIBIT.
- Normal send: wr with din=0xED, device model clocking at 12.5 kHz with ACK -> device samples start=0, bits 1,0,1,1,0,1,1,1 (LSB first), parity=1, stop=1; done pulses once; err=00.
- Parity check: din=0xF4 -> parity bit 0. din=0x00 -> parity bit 1, data bits all 0.
- No ACK: device leaves PS2D high on the 11th clock -> err=01, done pulses once, both oe=0 afterwards.
- Timeout: device stops clocking after the 4th fall -> TIMEOUT_CYCLES cycles later oe=00, err=10, done=1; wr pulsed during the stall is ignored (din unchanged on retry).
- Inhibit timing and filtering: ps2c_oe high for exactly INHIBIT_CYCLES cycles; ps2d_oe rises 1 cycle before ps2c_oe falls. A 3-cycle low glitch on PS2C during SHIFT does not advance the bit count.
